// File: rtl/spi_byte_sequencer.sv
// Upstream controller for the 8-bit SPI byte engine: feeds TX bytes back-to-back under one CS,
// inserts CS-high gaps between engine runs, and buffers received bytes in a small RX FIFO.
module spi_byte_sequencer #(
    parameter int LEN_W    = 8,
    parameter int RX_DEPTH = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_start,
    input  logic [LEN_W-1:0] I_len,
    input  logic             I_tx_valid,
    input  logic [7:0]       I_tx_data,
    output logic             O_tx_ready,
    output logic             O_rx_valid,
    output logic [7:0]       O_rx_data,
    input  logic             I_rx_ready,
    output logic             O_busy,
    output logic             O_done,
    output logic             O_underrun,
    output logic             O_spi_en,
    output logic [7:0]       O_spi_data,
    input  logic             I_spi_tx_done,
    input  logic             I_spi_rx_done,
    input  logic [7:0]       I_spi_rx_data
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    // A new byte needs one free slot when nothing is in flight, two when the current byte
    // has not been pushed yet.
    localparam logic [CNT_W-1:0] ROOM_IDLE = CNT_W'(RX_DEPTH - 1);
    localparam logic [CNT_W-1:0] ROOM_RUN  = CNT_W'(RX_DEPTH - 2);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RX_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TX,
        S_RUN,
        S_GAP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_remaining, w_remaining_nxt, w_rem_dec;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic             r_spi_en, w_spi_en_nxt;
    logic [7:0]       r_spi_data;
    logic             r_underrun, w_underrun;
    logic             r_last_pending, w_last_tx;
    logic             r_done;
    logic             w_accept;

    logic [7:0]       r_mem [RX_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_rx_count;
    logic             w_push, w_pop, w_rx_valid;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_spi_en_nxt    = r_spi_en;
        w_accept        = 1'b0;
        w_underrun      = 1'b0;
        w_last_tx       = 1'b0;
        w_rem_dec       = r_remaining - LEN_W'(1);
        case (r_state)
            S_IDLE: begin
                if (I_start && (I_len != '0)) begin
                    w_remaining_nxt = I_len;
                    w_state_nxt     = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (I_tx_valid && (r_rx_count <= ROOM_IDLE)) begin
                    w_accept     = 1'b1;
                    w_spi_en_nxt = 1'b1;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (I_spi_tx_done) begin
                    w_remaining_nxt = w_rem_dec;
                    w_last_tx       = (w_rem_dec == '0);
                    if ((w_rem_dec != '0) && I_tx_valid && (r_rx_count <= ROOM_RUN)) begin
                        w_accept = 1'b1;
                    end else begin
                        // Engine still finishes cycle 15 after en drops on this edge.
                        w_spi_en_nxt  = 1'b0;
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = '0;
                        w_underrun    = (w_rem_dec != '0) && !I_tx_valid;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = (r_remaining == '0) ? S_IDLE : S_WAIT_TX;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state        <= S_IDLE;
            r_remaining    <= '0;
            r_gap_cnt      <= '0;
            r_spi_en       <= 1'b0;
            r_spi_data     <= '0;
            r_underrun     <= 1'b0;
            r_last_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_spi_en    <= w_spi_en_nxt;
            r_underrun  <= w_underrun;
            r_done      <= I_spi_rx_done && r_last_pending;
            if (w_accept) begin
                r_spi_data <= I_tx_data;
            end
            // The final byte lands in the FIFO one cycle after its tx_done.
            if (w_last_tx) begin
                r_last_pending <= 1'b1;
            end else if (I_spi_rx_done) begin
                r_last_pending <= 1'b0;
            end
        end
    end

    assign w_push     = I_spi_rx_done;
    assign w_rx_valid = (r_rx_count != '0);
    assign w_pop      = w_rx_valid && I_rx_ready;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_rx_count <= r_rx_count + CNT_W'(1);
                2'b01:   r_rx_count <= r_rx_count - CNT_W'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count gates the output instead.
    always_ff @(posedge I_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= I_spi_rx_data;
        end
    end

    a_no_push_when_full: assert property (@(posedge I_clk) disable iff (!I_rst_n)
        !(w_push && (r_rx_count == FIFO_FULL)));

    assign O_tx_ready = w_accept;
    assign O_rx_valid = w_rx_valid;
    assign O_rx_data  = w_rx_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign O_busy     = (r_state != S_IDLE);
    assign O_done     = r_done;
    assign O_underrun = r_underrun;
    assign O_spi_en   = r_spi_en;
    assign O_spi_data = r_spi_data;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: a loopback engine model, a table of transactions scored through
// an RX scoreboard queue, and hand-written reset / ignored-start sequences.
module tb_spi_byte_sequencer;

    localparam int LEN_W    = 8;
    localparam int RX_DEPTH = 4;
    localparam int GAP_CYC  = 2;

    logic             I_clk;
    logic             I_rst_n;
    logic             I_start;
    logic [LEN_W-1:0] I_len;
    logic             I_tx_valid;
    logic [7:0]       I_tx_data;
    logic             O_tx_ready;
    logic             O_rx_valid;
    logic [7:0]       O_rx_data;
    logic             I_rx_ready;
    logic             O_busy;
    logic             O_done;
    logic             O_underrun;
    logic             O_spi_en;
    logic [7:0]       O_spi_data;
    logic             I_spi_tx_done;
    logic             I_spi_rx_done;
    logic [7:0]       I_spi_rx_data;

    spi_byte_sequencer #(
        .LEN_W    (LEN_W),
        .RX_DEPTH (RX_DEPTH),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .I_clk         (I_clk),
        .I_rst_n       (I_rst_n),
        .I_start       (I_start),
        .I_len         (I_len),
        .I_tx_valid    (I_tx_valid),
        .I_tx_data     (I_tx_data),
        .O_tx_ready    (O_tx_ready),
        .O_rx_valid    (O_rx_valid),
        .O_rx_data     (O_rx_data),
        .I_rx_ready    (I_rx_ready),
        .O_busy        (O_busy),
        .O_done        (O_done),
        .O_underrun    (O_underrun),
        .O_spi_en      (O_spi_en),
        .O_spi_data    (O_spi_data),
        .I_spi_tx_done (I_spi_tx_done),
        .I_spi_rx_done (I_spi_rx_done),
        .I_spi_rx_data (I_spi_rx_data)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Engine model with MISO looped to MOSI: the byte sampled at the end of cycle 0 comes back.
    logic [3:0] eng_cnt;
    logic [7:0] eng_sh;
    always @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            eng_cnt       <= 4'd0;
            eng_sh        <= 8'd0;
            I_spi_rx_done <= 1'b0;
            I_spi_rx_data <= 8'd0;
        end else begin
            I_spi_rx_done <= O_spi_en && (eng_cnt == 4'd15);
            if (O_spi_en && (eng_cnt == 4'd15)) I_spi_rx_data <= eng_sh;
            if (O_spi_en && (eng_cnt == 4'd0)) eng_sh <= O_spi_data;
            eng_cnt <= O_spi_en ? eng_cnt + 4'd1 : 4'd0;
        end
    end
    assign I_spi_tx_done = O_spi_en && (eng_cnt == 4'd15);

    int n_tests;
    int n_fail;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int len;
        int base;
        int step;
        int late_idx;     // TX byte index held invalid until late_cyc
        int late_cyc;
        int rx_hold;      // host ready stays low until this cycle
        int restart_cyc;  // extra start pulse (len 5) while busy, -1 = none
        int exp_runs;
        int exp_under;
        int exp_en_rel;   // en-high cycles seen when host ready rises
    } vec_t;

    vec_t vecs[7];

    task automatic drive_tx(input vec_t v, input int idx, input int c);
        I_tx_valid = (idx < v.len) && !((idx == v.late_idx) && (c < v.late_cyc));
        I_tx_data  = 8'(v.base + v.step * idx);
    endtask

    task automatic run_txn(input string name, input vec_t v);
        int tx_idx = 0, en_cnt = 0, runs = 0, under = 0, dones = 0;
        int first_en = -1, last_en = -1, done_cyc = -1, t_idle = -1;
        int low_len = 0, min_low = 100000, en_rel = -1, rx_got = 0, viol = 0;
        bit prev_en = 1'b0, finished = 1'b0;
        logic [7:0] prev_data = 8'd0;
        logic [7:0] exp_b;
        exp_q.delete();
        @(posedge I_clk); #1;
        I_start    = 1'b1;
        I_len      = LEN_W'(v.len);
        I_rx_ready = (v.rx_hold <= 0);
        if (I_rx_ready) en_rel = 0;
        drive_tx(v, tx_idx, 0);
        for (int c = 0; c < 1500; c++) begin
            @(negedge I_clk);
            if (I_tx_valid && O_tx_ready) begin
                exp_q.push_back(I_tx_data);
                tx_idx++;
            end
            if (O_spi_en) begin
                if (!prev_en) begin
                    if (runs > 0 && low_len < min_low) min_low = low_len;
                    low_len = 0;
                    runs++;
                end
                if (first_en < 0) first_en = c;
                last_en = c;
                en_cnt++;
                if (eng_cnt != 4'd0 && O_spi_data != prev_data) viol++;
            end else if (runs > 0) begin
                low_len++;
            end
            prev_en   = O_spi_en;
            prev_data = O_spi_data;
            if (O_underrun) under++;
            if (O_done) begin
                dones++;
                done_cyc = c;
            end
            if (c > 0 && !O_busy && t_idle < 0) t_idle = c;
            if (O_rx_valid && I_rx_ready) begin
                check({name, " rx_expected"}, int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check({name, " rx_data"}, int'(O_rx_data), int'(exp_b));
                end
                rx_got++;
            end
            if (c > 0 && dones > 0 && rx_got >= v.len && !O_busy) begin
                finished = 1'b1;
                break;
            end
            @(posedge I_clk); #1;
            I_start = (c + 1 == v.restart_cyc);
            I_len   = (c + 1 == v.restart_cyc) ? LEN_W'(5) : LEN_W'(v.len);
            if (!I_rx_ready && c + 1 >= v.rx_hold) begin
                I_rx_ready = 1'b1;
                en_rel     = en_cnt;
            end
            drive_tx(v, tx_idx, c + 1);
        end
        I_start    = 1'b0;
        I_tx_valid = 1'b0;
        I_rx_ready = 1'b1;
        check({name, " finished"}, int'(finished), 1);
        check({name, " en_cycles"}, en_cnt, 16 * v.len);
        check({name, " en_runs"}, runs, v.exp_runs);
        check({name, " underruns"}, under, v.exp_under);
        check({name, " done_pulses"}, dones, 1);
        check({name, " start_to_en"}, first_en, 2);
        check({name, " busy_drop"}, t_idle - last_en, GAP_CYC + 1);
        check({name, " done_timing"}, done_cyc - last_en, 2);
        check({name, " rx_count"}, rx_got, v.len);
        check({name, " data_stable"}, viol, 0);
        check({name, " en_at_release"}, en_rel, v.exp_en_rel);
        if (runs > 1) check({name, " min_gap"}, int'(min_low >= GAP_CYC), 1);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int busy_hi;
        int k;
        n_tests    = 0;
        n_fail     = 0;
        I_rst_n    = 1'b0;
        I_start    = 1'b0;
        I_len      = '0;
        I_tx_valid = 1'b1;
        I_tx_data  = 8'hC3;
        I_rx_ready = 1'b1;

        //           len base   step  late_idx late_cyc hold restart runs under rel
        vecs[0] = '{1, 'hA5, 'h00, -1,  0,  0,   -1, 1, 0, 0};
        vecs[1] = '{3, 'h01, 'h01, -1,  0,  0,   -1, 1, 0, 0};
        vecs[2] = '{2, 'h5A, 'h11,  1, 58,  0,   -1, 2, 1, 0};
        vecs[3] = '{6, 'h10, 'h13, -1,  0,  200, -1, 2, 0, 64};
        vecs[4] = '{1, 'h3C, 'h00, -1,  0,  0,    6, 1, 0, 0};
        vecs[5] = '{9, 'hF7, 'h25, -1,  0,  0,   -1, 1, 0, 0};
        vecs[6] = '{4, 'h80, 'h07,  2, 60,  0,   -1, 2, 1, 0};

        repeat (3) @(posedge I_clk);
        #1;
        check("reset outputs", int'({O_busy, O_done, O_underrun, O_spi_en, O_rx_valid, O_tx_ready}), 0);
        check("reset spi_data", int'(O_spi_data), 0);
        check("reset rx_data", int'(O_rx_data), 0);
        @(negedge I_clk);
        I_rst_n = 1'b1;
        @(negedge I_clk);
        check("idle tx_ready", int'(O_tx_ready), 0);
        I_tx_valid = 1'b0;

        // Zero-length start must be ignored.
        @(posedge I_clk); #1;
        I_start = 1'b1;
        I_len   = '0;
        @(posedge I_clk); #1;
        I_start = 1'b0;
        busy_hi = 0;
        repeat (4) begin
            @(negedge I_clk);
            if (O_busy) busy_hi++;
        end
        check("len0 busy", busy_hi, 0);

        run_txn("single", vecs[0]);
        run_txn("burst3", vecs[1]);
        run_txn("underrun", vecs[2]);
        run_txn("rx_backpressure", vecs[3]);
        run_txn("start_while_busy", vecs[4]);
        run_txn("burst9", vecs[5]);
        run_txn("underrun_mid", vecs[6]);

        // Reset at engine cycle 7 of byte 2, with byte 1 still sitting in the FIFO.
        @(posedge I_clk); #1;
        I_rx_ready = 1'b0;
        I_tx_valid = 1'b1;
        I_tx_data  = 8'h77;
        I_start    = 1'b1;
        I_len      = LEN_W'(2);
        @(posedge I_clk); #1;
        I_start = 1'b0;
        k = 0;
        while (!(O_spi_en && eng_cnt == 4'd7 && O_rx_valid) && k < 200) begin
            @(negedge I_clk);
            k++;
        end
        check("mid_reset reached", int'(k < 200), 1);
        #2 I_rst_n = 1'b0;
        #1;
        check("mid_reset outputs", int'({O_busy, O_done, O_underrun, O_spi_en, O_rx_valid, O_tx_ready}), 0);
        check("mid_reset spi_data", int'(O_spi_data), 0);
        check("mid_reset rx_data", int'(O_rx_data), 0);
        repeat (2) @(negedge I_clk);
        I_rst_n    = 1'b1;
        I_tx_valid = 1'b0;
        I_rx_ready = 1'b1;
        @(negedge I_clk);
        check("post_reset rx_valid", int'(O_rx_valid), 0);

        v      = vecs[0];
        v.base = 'h4B;
        run_txn("after_reset", v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
